// File: rtl/au_signapply_pkg.sv
// au_signapply_pkg: shared FSM state type and sizing helpers for the digit-serial sign applier
package au_signapply_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Number of DIGIT-wide slices needed to cover WIDTH bits
    function automatic int ndig_f(input int width, input int digit);
        return (width + (digit < 1 ? 1 : digit) - 1) / (digit < 1 ? 1 : digit);
    endfunction

    // Digit counter width, wide enough to hold NDIG
    function automatic int cnt_w_f(input int width, input int digit);
        return $clog2(ndig_f(width, digit) + 1);
    endfunction

endpackage

// File: rtl/au_signapply_digit.sv
// au_signapply_digit: one LSB-first slice of the copy-through-first-one / invert-above rule
module au_signapply_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] d_i,
    input  logic             seen_i,
    input  logic             sign_i,
    output logic [DIGIT-1:0] r_o,
    output logic             seen_o
);

    logic [DIGIT:0] seen;

    assign seen[0] = seen_i;
    assign seen_o  = seen[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign seen[i+1] = seen[i] | d_i[i];
        assign r_o[i]    = d_i[i] ^ (sign_i & seen[i]);
    end

endmodule

// File: rtl/au_signapply_seq.sv
// au_signapply_seq: digit-serial sign-magnitude to two's-complement converter with valid/ready.
// Optional AU_SIGNAPPLY_FASTPATH_EN: words with sign=0 or mag=0 skip BUSY and go straight to DONE.
module au_signapply_seq
    import au_signapply_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mag,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             ovf
);

    localparam int NDIG = ndig_f(WIDTH, DIGIT);
    localparam int CW   = cnt_w_f(WIDTH, DIGIT);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_signapply_seq: parameter WIDTH must be >= 1");
    end
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $fatal(1, "au_signapply_seq: parameter DIGIT must be in 1..WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sign_q, sign_d;
    logic             seen_q, seen_d;
    logic             ovf_q, ovf_d;
    logic [DIGIT-1:0] res;
    logic             seen_nx;
    logic             fast;

    au_signapply_digit #(.DIGIT(DIGIT)) u_digit (
        .d_i    (sh_q[DIGIT-1:0]),
        .seen_i (seen_q),
        .sign_i (sign_q),
        .r_o    (res),
        .seen_o (seen_nx)
    );

`ifdef AU_SIGNAPPLY_FASTPATH_EN
    assign fast = !sign || (mag == '0);
`else
    assign fast = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = acc_q;
    assign ovf       = ovf_q;

    // Next state: load on accept, convert one slice per BUSY cycle, hold in DONE until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                sh_d    = mag;
                sign_d  = sign;
                seen_d  = 1'b0;
                cnt_d   = '0;
                ovf_d   = sign ? (mag > HALF) : mag[WIDTH-1];
                acc_d   = fast ? mag : '0;
                state_d = fast ? DONE : BUSY;
            end
        end else if (state_q == BUSY) begin
            sh_d   = sh_q >> DIGIT;
            acc_d  = acc_q | (WIDTH'(res) << (cnt_q * DIGIT));
            seen_d = seen_nx;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(NDIG - 1)) state_d = DONE;
        end else if (out_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_au_signapply_seq.sv
// tb_au_signapply_seq: table vectors plus scoreboard for an 8/4 and a 7/3 instance
module tb_au_signapply_seq;

    localparam int NDA = 2;
    localparam int NDB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_sign, a_out_valid, a_out_ready, a_ovf;
    logic [7:0] a_mag, a_z;
    logic       b_in_valid, b_in_ready, b_sign, b_out_valid, b_out_ready, b_ovf;
    logic [6:0] b_mag, b_z;

    au_signapply_seq #(.WIDTH(8), .DIGIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mag(a_mag), .sign(a_sign), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .z(a_z), .ovf(a_ovf)
    );

    au_signapply_seq #(.WIDTH(7), .DIGIT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mag(b_mag), .sign(b_sign), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .z(b_z), .ovf(b_ovf)
    );

    typedef struct {logic [7:0] z; logic ovf;} res_t;
    typedef struct {logic s; logic [7:0] m; logic [7:0] ez; logic eo;} vec_t;

    res_t qa[$];
    res_t qb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [7:0] m, input int w);
        res_t r;
        int v;
        int lim;
        lim = 1 << (w - 1);
        v = s ? -int'(m) : int'(m);
        r.z = 8'(v) & 8'((1 << w) - 1);
        r.ovf = (v > lim - 1) || (v < -lim);
        return r;
    endfunction

    function automatic int exp_lat(input logic s, input logic [7:0] m, input int nd);
`ifdef AU_SIGNAPPLY_FASTPATH_EN
        return (!s || m == 8'h00) ? 0 : nd;
`else
        return nd;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            res_t e;
            if (qa.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected: got z=%0h, expected no output", a_z);
            end else begin
                e = qa.pop_front();
                chk("a_z", a_z, e.z);
                chk("a_ovf", a_ovf, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            res_t e;
            if (qb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected: got z=%0h, expected no output", b_z);
            end else begin
                e = qb.pop_front();
                chk("b_z", b_z, e.z);
                chk("b_ovf", b_ovf, e.ovf);
            end
        end
    end

    task automatic send_a(input logic s, input logic [7:0] m, input logic [7:0] ez, input logic eo);
        int lat = 0;
        int w = 0;
        res_t e;
        @(negedge clk);
        a_sign = s;
        a_mag = m;
        a_in_valid = 1'b1;
        e.z = ez;
        e.ovf = eo;
        qa.push_back(e);
        while (!a_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("a_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("a_latency", lat, exp_lat(s, m, NDA));
    endtask

    task automatic send_b(input logic s, input logic [6:0] m, input logic [7:0] ez, input logic eo);
        int lat = 0;
        int w = 0;
        res_t e;
        @(negedge clk);
        b_sign = s;
        b_mag = m;
        b_in_valid = 1'b1;
        e.z = ez;
        e.ovf = eo;
        qb.push_back(e);
        while (!b_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("b_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        while (!b_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b_latency", lat, exp_lat(s, {1'b0, m}, NDB));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ta[10];
        vec_t tb[7];
        res_t r;
        int w;
        int lat;
        logic s;
        logic [7:0] m;
        ta = '{
            '{1'b1, 8'h05, 8'hFB, 1'b0}, '{1'b1, 8'h80, 8'h80, 1'b0},
            '{1'b1, 8'h81, 8'h7F, 1'b1}, '{1'b0, 8'h90, 8'h90, 1'b1},
            '{1'b1, 8'h00, 8'h00, 1'b0}, '{1'b0, 8'h12, 8'h12, 1'b0},
            '{1'b1, 8'h12, 8'hEE, 1'b0}, '{1'b0, 8'h7F, 8'h7F, 1'b0},
            '{1'b1, 8'hFF, 8'h01, 1'b1}, '{1'b0, 8'h00, 8'h00, 1'b0}
        };
        tb = '{
            '{1'b1, 8'h01, 8'h7F, 1'b0}, '{1'b1, 8'h40, 8'h40, 1'b0},
            '{1'b1, 8'h41, 8'h3F, 1'b1}, '{1'b0, 8'h40, 8'h40, 1'b1},
            '{1'b1, 8'h00, 8'h00, 1'b0}, '{1'b0, 8'h3F, 8'h3F, 1'b0},
            '{1'b1, 8'h7F, 8'h01, 1'b1}
        };
        a_in_valid = 1'b0; a_sign = 1'b0; a_mag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_sign = 1'b0; b_mag = '0; b_out_ready = 1'b1;
        #2;
        chk("a_rst_in_ready", a_in_ready, 1);
        chk("a_rst_out_valid", a_out_valid, 0);
        chk("a_rst_z", a_z, 0);
        chk("a_rst_ovf", a_ovf, 0);
        chk("b_rst_in_ready", b_in_ready, 1);
        chk("b_rst_out_valid", b_out_valid, 0);
        chk("b_rst_z", b_z, 0);
        chk("b_rst_ovf", b_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) send_a(ta[i].s, ta[i].m, ta[i].ez, ta[i].eo);
        for (int i = 0; i < 7; i++) send_b(tb[i].s, tb[i].m[6:0], tb[i].ez, tb[i].eo);

        // backpressure: result held while a new word waits at the input
        a_out_ready = 1'b0;
        send_a(1'b1, 8'h05, 8'hFB, 1'b0);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_sign = 1'b0;
        a_mag = 8'h33;
        for (int i = 0; i < 5; i++) begin
            chk("bp_z", a_z, 8'hFB);
            chk("bp_ovf", a_ovf, 0);
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_out_valid", a_out_valid, 1);
            @(negedge clk);
        end
        r = model(1'b0, 8'h33, 8);
        qa.push_back(r);
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!a_in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_accept", a_in_ready, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat, exp_lat(1'b0, 8'h33, NDA));

        // reset one cycle into BUSY drops the word
        @(negedge clk);
        @(negedge clk);
        a_sign = 1'b1;
        a_mag = 8'h22;
        a_in_valid = 1'b1;
        chk("rst_pre_ready", a_in_ready, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", a_in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", a_out_valid, 0);
        chk("rst_mid_z", a_z, 0);
        chk("rst_mid_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send_a(1'b1, 8'h01, 8'hFF, 1'b0);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            m = 8'($urandom_range(0, 255));
            r = model(s, m, 8);
            send_a(s, m, r.z, r.ovf);
            m = 8'($urandom_range(0, 127));
            r = model(s, m, 7);
            send_b(s, m[6:0], r.z, r.ovf);
        end

        repeat (4) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
